// File: rtl/alsu_collect_pkg.sv
// rtl/alsu_collect_pkg.sv - shared types and opcode constants for the ALSU result collector
//
// Contents:
//   opcode_t      3-bit ALSU opcode
//   entry_t       packed FIFO entry {opcode, err, data[5:0]}
//   ENTRY_W       width of entry_t (10 bits)
//   even_parity   even-parity bit over an entry (used when ALSU_COLLECT_PARITY_EN is defined)
package alsu_collect_pkg;

  typedef logic [2:0] opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic       err;
    logic [5:0] data;
  } entry_t;

  localparam opcode_t OR       = 3'd0;
  localparam opcode_t XOR      = 3'd1;
  localparam opcode_t ADD      = 3'd2;
  localparam opcode_t MULT     = 3'd3;
  localparam opcode_t SHIFT    = 3'd4;
  localparam opcode_t ROTATE   = 3'd5;
  localparam opcode_t INVALID6 = 3'd6;
  localparam opcode_t INVALID7 = 3'd7;

  localparam int ENTRY_W = $bits(entry_t);

  // XOR-reduce so that {parity, entry} has an even number of ones.
  function automatic logic even_parity(input entry_t e);
    return ^e;
  endfunction

endpackage

// File: rtl/alsu_collect_fifo.sv
// rtl/alsu_collect_fifo.sv - synchronous FIFO holding tagged ALSU result entries
//
// Parameters:
//   DEPTH    number of entries (power of 2, 2..16)
//   W        entry width in bits
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset (pointers and level only)
//   push      in   write wr_data at the tail; caller only pushes when not full or popping
//   pop       in   advance the head; caller only pops when not empty
//   wr_data   in   W  entry to write
//   rd_data   out  W  head entry, read combinationally from storage
//   full      out  level == DEPTH
//   empty     out  level == 0
//   level     out  $clog2(DEPTH)+1  current occupancy
module alsu_collect_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset; the head is only consumed when level says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/alsu_result_collector.sv
// rtl/alsu_result_collector.sv - tags ALSU results with their opcode, flags invalid-op events, buffers them
//
// Optional feature: define ALSU_COLLECT_PARITY_EN to store an even-parity bit per entry and
// add the rd_par / par_fault outputs.
//
// Parameters:
//   DEPTH     FIFO entries (power of 2, 2..16)
//   LATENCY   cycles from command issue to ALSU out update (1..4)
//   ERR_W     width of the saturating error counter
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   cmd_valid   in   command presented to the ALSU this cycle
//   cmd_opcode  in   3   opcode presented to the ALSU this cycle
//   alsu_out    in   6   ALSU out
//   alsu_leds   in   16  ALSU leds
//   clr         in   synchronous clear of err_cnt and overflow
//   rd_valid    out  head entry available
//   rd_ready    in   consumer accepts head entry
//   rd_opcode   out  3   head opcode
//   rd_data     out  6   head result
//   rd_err      out  head was an invalid-op event
//   level       out  $clog2(DEPTH)+1  occupancy
//   overflow    out  sticky: a push was dropped
//   rd_par      out  head stored parity (ALSU_COLLECT_PARITY_EN only)
//   par_fault   out  sticky: parity mismatch seen on pop (ALSU_COLLECT_PARITY_EN only)
//   err_cnt     out  ERR_W  saturating count of captured invalid-op events
module alsu_result_collector
  import alsu_collect_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int ERR_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd_opcode,
  input  logic [5:0]             alsu_out,
  input  logic [15:0]            alsu_leds,
  input  logic                   clr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [2:0]             rd_opcode,
  output logic [5:0]             rd_data,
  output logic                   rd_err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
`ifdef ALSU_COLLECT_PARITY_EN
  output logic                   rd_par,
  output logic                   par_fault,
`endif
  output logic [ERR_W-1:0]       err_cnt
);

`ifdef ALSU_COLLECT_PARITY_EN
  localparam int FIFO_W = ENTRY_W + 1;
`else
  localparam int FIFO_W = ENTRY_W;
`endif

  logic [LATENCY-1:0] tag_valid;
  opcode_t            tag_opcode [LATENCY];
  logic               cap_valid;
  opcode_t            cap_opcode;

  logic [15:0]        leds_q;
  logic               ev_err;

  entry_t             cap_entry;
  entry_t             head;
  logic [FIFO_W-1:0]  fifo_wdata;
  logic [FIFO_W-1:0]  fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               drop;

  // Tag pipeline: the command issued LATENCY cycles ago is the one whose result is on alsu_out now.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_opcode[i] <= '0;
      end
    end else begin
      tag_valid[0]  <= cmd_valid;
      tag_opcode[0] <= cmd_opcode;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i]  <= tag_valid[i-1];
        tag_opcode[i] <= tag_opcode[i-1];
      end
    end
  end

  assign cap_valid  = tag_valid[LATENCY-1];
  assign cap_opcode = tag_opcode[LATENCY-1];

  // The ALSU inverts leds on an invalid operation, so any change of leds marks an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_q <= 16'h0000;
    end else begin
      leds_q <= alsu_leds;
    end
  end

  assign ev_err = (alsu_leds != leds_q);

  assign cap_entry = '{opcode: cap_opcode, err: ev_err, data: alsu_out};

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = rd_valid && rd_ready;
  assign push = cap_valid && (!fifo_full || pop);
  assign drop = cap_valid && fifo_full && !pop;

`ifdef ALSU_COLLECT_PARITY_EN
  assign fifo_wdata = {even_parity(cap_entry), cap_entry};
`else
  assign fifo_wdata = cap_entry;
`endif

  alsu_collect_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wdata),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Head fields are forced to zero while empty so stale storage never shows on the port.
  assign head      = entry_t'(fifo_rdata[ENTRY_W-1:0]);
  assign rd_valid  = !fifo_empty;
  assign rd_opcode = fifo_empty ? 3'd0 : head.opcode;
  assign rd_data   = fifo_empty ? 6'd0 : head.data;
  assign rd_err    = fifo_empty ? 1'b0 : head.err;

`ifdef ALSU_COLLECT_PARITY_EN
  assign rd_par = fifo_empty ? 1'b0 : fifo_rdata[ENTRY_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_fault <= 1'b0;
    end else if (pop && (even_parity(head) != fifo_rdata[ENTRY_W])) begin
      par_fault <= 1'b1;
    end
  end
`endif

  // clr takes priority over a same-cycle increment or overflow set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && ev_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alsu_result_collector.sv
// tb/tb_alsu_result_collector.sv - self-checking bench for alsu_result_collector
module tb_alsu_result_collector;
  import alsu_collect_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_opcode = 3'd0;
  logic [5:0]  alsu_out = 6'd0;
  logic [15:0] alsu_leds = 16'h0000;
  logic        clr = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [2:0]  rd_opcode;
  logic [5:0]  rd_data;
  logic        rd_err;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  alsu_result_collector #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .ERR_W   (ERR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .alsu_out   (alsu_out),
    .alsu_leds  (alsu_leds),
    .clr        (clr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_opcode  (rd_opcode),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .level      (level),
    .overflow   (overflow),
    .err_cnt    (err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: commands waiting for their result (stamped with issue cycle) and the FIFO as a queue.
  typedef struct {
    int         t;
    logic [2:0] op;
  } tag_t;

  tag_t        pend[$];
  entry_t      mq[$];
  logic [15:0] m_leds;
  logic        m_ovf;
  int          m_err;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_leds = 16'h0000;
    m_ovf  = 1'b0;
    m_err  = 0;
  endtask

  task automatic model_step();
    logic       cap;
    logic [2:0] cop;
    logic       pop;
    logic       ev;
    logic       acc;
    entry_t     e;
    if (!reset_n) begin
      model_reset();
      cyc++;
      return;
    end
    cap = 1'b0;
    cop = 3'd0;
    if (pend.size() > 0 && pend[0].t + LATENCY == cyc) begin
      cap = 1'b1;
      cop = pend[0].op;
      pend.delete(0);
    end
    pop = (mq.size() > 0) && rd_ready;
    ev  = (alsu_leds != m_leds);
    acc = cap && ((mq.size() < DEPTH) || pop);
    if (pop) mq.delete(0);
    if (acc) begin
      e.opcode = cop;
      e.err    = ev;
      e.data   = alsu_out;
      mq.push_back(e);
    end
    if (clr) begin
      m_err = 0;
      m_ovf = 1'b0;
    end else begin
      if (acc && ev && m_err < ERR_MAX) m_err++;
      if (cap && !acc) m_ovf = 1'b1;
    end
    m_leds = alsu_leds;
    if (cmd_valid) pend.push_back('{cyc, cmd_opcode});
    cyc++;
  endtask

  task automatic compare_all();
    check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("rd_opcode", 32'(rd_opcode), 32'(mq[0].opcode));
      check("rd_data", 32'(rd_data), 32'(mq[0].data));
      check("rd_err", 32'(rd_err), 32'(mq[0].err));
    end else begin
      check("rd_opcode_idle", 32'(rd_opcode), 32'd0);
      check("rd_data_idle", 32'(rd_data), 32'd0);
      check("rd_err_idle", 32'(rd_err), 32'd0);
    end
    check("level", 32'(level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // Reset state
    model_reset();
    #1;
    compare_all();
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single command: opcode 2 issued at cycle 0, result 5 at cycle 2, visible at cycle 3
    cmd_valid = 1'b1; cmd_opcode = 3'b010; alsu_out = 6'h00; tick();
    cmd_valid = 1'b0; tick();
    alsu_out = 6'h05; tick();
    check("t1_valid", 32'(rd_valid), 32'd1);
    check("t1_opcode", 32'(rd_opcode), 32'd2);
    check("t1_data", 32'(rd_data), 32'd5);
    check("t1_err", 32'(rd_err), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    // Held while not ready
    alsu_out = 6'h2A; tick();
    check("t1_hold", 32'(rd_data), 32'd5);
    rd_ready = 1'b1; tick();
    rd_ready = 1'b0;

    // Invalid opcode with leds inversion in the capture cycle
    cmd_valid = 1'b1; cmd_opcode = 3'b110; tick();
    cmd_valid = 1'b0; tick();
    alsu_out = 6'h3F; alsu_leds = 16'hFFFF; tick();
    check("t2_err", 32'(rd_err), 32'd1);
    check("t2_opcode", 32'(rd_opcode), 32'd6);
    check("t2_cnt", 32'(err_cnt), 32'd1);
    rd_ready = 1'b1; tick();
    rd_ready = 1'b0;

    // Five back-to-back commands, no reads: fifth is dropped
    for (int i = 0; i < 7; i++) begin
      cmd_valid  = (i < 5);
      cmd_opcode = 3'(i);
      alsu_out   = 6'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_level", 32'(level), 32'd4);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head", 32'(rd_opcode), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_ready = 1'b0;
    check("t3_drained", 32'(level), 32'd0);
    clr = 1'b1; tick();
    clr = 1'b0;
    check("t3_clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with pop and push in the same cycle
    for (int i = 0; i < 6; i++) begin
      cmd_valid  = (i < 4);
      cmd_opcode = 3'(i + 1);
      alsu_out   = 6'($urandom);
      tick();
    end
    check("t4_full", 32'(level), 32'd4);
    cmd_valid = 1'b1; cmd_opcode = 3'd7; tick();
    cmd_valid = 1'b0; tick();
    rd_ready = 1'b1; alsu_out = 6'h11; tick();
    rd_ready = 1'b0;
    check("t4_level", 32'(level), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Saturation of err_cnt: an event on every captured result
    cmd_valid = 1'b1;
    for (int i = 0; i < ERR_MAX + 8; i++) begin
      cmd_opcode = 3'($urandom);
      alsu_out   = 6'($urandom);
      alsu_leds  = ~alsu_leds;
      tick();
    end
    check("t5_sat", 32'(err_cnt), 32'hFF);
    clr = 1'b1; alsu_leds = ~alsu_leds; tick();
    clr = 1'b0;
    check("t5_clr_cnt", 32'(err_cnt), 32'd0);
    check("t5_clr_ovf", 32'(overflow), 32'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rd_ready = 1'b0;

    // Reset mid-stream: 3 entries queued, 2 tags in flight
    for (int i = 0; i < 5; i++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 3'(i);
      alsu_out   = 6'($urandom);
      alsu_leds  = 16'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    check("t6_queued", 32'(level), 32'd3);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_cnt", 32'(err_cnt), 32'd0);
    check("t6_rst_data", 32'(rd_data), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    alsu_leds = 16'h0000;
    for (int i = 0; i < 4; i++) tick();
    check("t6_no_capture", 32'(level), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_opcode = 3'($urandom);
      alsu_out   = 6'($urandom);
      if ($urandom_range(0, 3) == 0) alsu_leds = 16'($urandom);
      rd_ready   = ($urandom_range(0, 2) == 0);
      clr        = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
